// File: rtl/lc3_mem_sys.sv
// LC-3 memory subsystem: MAR, word RAM, keyboard/display memory-mapped registers
// and a READ_LAT-deep registered read pipeline feeding data_out.
module lc3_mem_sys #(
  parameter int RAM_AW   = 12,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        memWE,
  input  logic        ldMAR,
  output logic [15:0] data_out,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_char,
  output logic        kbd_ready,
  output logic        ddr_valid,
  output logic [7:0]  ddr_char,
  input  logic        ddr_ack
);

  localparam logic [15:0] IO_BASE = 16'hFE00;
  localparam logic [15:0] KBSR    = 16'hFE00;
  localparam logic [15:0] KBDR    = 16'hFE02;
  localparam logic [15:0] DSR     = 16'hFE04;
  localparam logic [15:0] DDR     = 16'hFE06;

  logic [15:0] mem [0:(1<<RAM_AW)-1];

  logic [15:0] mar_q, mar_d;
  logic        kbd_full_q, kbd_full_d;
  logic [7:0]  kbdr_q, kbdr_d;
  logic        ddr_valid_q, ddr_valid_d;
  logic [7:0]  ddr_char_q, ddr_char_d;
  logic [15:0] pipe_q [READ_LAT];
  logic [15:0] rd_s;
  logic        ram_we_s;

  // Next-state for MAR and the I/O registers; all write decode uses the old MAR.
  always_comb begin
    mar_d       = mar_q;
    kbd_full_d  = kbd_full_q;
    kbdr_d      = kbdr_q;
    ddr_valid_d = ddr_valid_q;
    ddr_char_d  = ddr_char_q;
    ram_we_s    = memWE && (mar_q < IO_BASE);

    if (ldMAR) begin
      mar_d = addr;
    end else begin
      mar_d = mar_q;
    end

    // A char offered while the buffer is full is held off until after the clear.
    if (kbd_valid && !kbd_full_q) begin
      kbd_full_d = 1'b1;
      kbdr_d     = kbd_char;
    end else if (ldMAR && (addr == KBDR)) begin
      kbd_full_d = 1'b0;
    end else begin
      kbd_full_d = kbd_full_q;
    end

    if (ddr_ack && ddr_valid_q) begin
      ddr_valid_d = 1'b0;
    end else if (memWE && (mar_q == DDR) && !ddr_valid_q) begin
      ddr_valid_d = 1'b1;
      ddr_char_d  = data_in[7:0];
    end else begin
      ddr_valid_d = ddr_valid_q;
    end
  end

  // Read decode of the registered MAR.
  always_comb begin
    rd_s = 16'h0000;
    if (mar_q < IO_BASE) begin
      rd_s = mem[mar_q[RAM_AW-1:0]];
    end else begin
      case (mar_q)
        KBSR:    rd_s = {kbd_full_q, 15'b0};
        KBDR:    rd_s = {8'h00, kbdr_q};
        DSR:     rd_s = {~ddr_valid_q, 15'b0};
        DDR:     rd_s = {8'h00, ddr_char_q};
        default: rd_s = 16'h0000;
      endcase
    end
  end

  // State registers and read pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      mar_q       <= 16'h0000;
      kbd_full_q  <= 1'b0;
      kbdr_q      <= 8'h00;
      ddr_valid_q <= 1'b0;
      ddr_char_q  <= 8'h00;
      for (int i = 0; i < READ_LAT; i++) pipe_q[i] <= 16'h0000;
    end else begin
      mar_q       <= mar_d;
      kbd_full_q  <= kbd_full_d;
      kbdr_q      <= kbdr_d;
      ddr_valid_q <= ddr_valid_d;
      ddr_char_q  <= ddr_char_d;
      pipe_q[0]   <= rd_s;
      for (int i = 1; i < READ_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // RAM array is not reset; a write lands after this edge's read sample.
  always_ff @(posedge clk) begin
    if (!rst && ram_we_s) begin
      mem[mar_q[RAM_AW-1:0]] <= data_in;
    end
  end

  assign data_out  = pipe_q[READ_LAT-1];
  assign kbd_ready = ~kbd_full_q;
  assign ddr_valid = ddr_valid_q;
  assign ddr_char  = ddr_char_q;

endmodule

// File: tb/tb_lc3_mem_sys.sv
// Randomized bench for lc3_mem_sys: three instances (READ_LAT 1..3) share stimulus
// and are checked every cycle against a memory-map level reference model.
module tb_lc3_mem_sys;
  logic        clk = 1'b0;
  logic        rst, memWE, ldMAR, kbd_valid, ddr_ack;
  logic [15:0] addr, data_in;
  logic [7:0]  kbd_char;
  logic [15:0] dout [1:3];
  logic        kr [1:3];
  logic        dv [1:3];
  logic [7:0]  dc [1:3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lc3_mem_sys #(.RAM_AW(12), .READ_LAT(1)) u1 (.clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
    .memWE(memWE), .ldMAR(ldMAR), .data_out(dout[1]), .kbd_valid(kbd_valid), .kbd_char(kbd_char),
    .kbd_ready(kr[1]), .ddr_valid(dv[1]), .ddr_char(dc[1]), .ddr_ack(ddr_ack));
  lc3_mem_sys #(.RAM_AW(12), .READ_LAT(2)) u2 (.clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
    .memWE(memWE), .ldMAR(ldMAR), .data_out(dout[2]), .kbd_valid(kbd_valid), .kbd_char(kbd_char),
    .kbd_ready(kr[2]), .ddr_valid(dv[2]), .ddr_char(dc[2]), .ddr_ack(ddr_ack));
  lc3_mem_sys #(.RAM_AW(12), .READ_LAT(3)) u3 (.clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
    .memWE(memWE), .ldMAR(ldMAR), .data_out(dout[3]), .kbd_valid(kbd_valid), .kbd_char(kbd_char),
    .kbd_ready(kr[3]), .ddr_valid(dv[3]), .ddr_char(dc[3]), .ddr_ack(ddr_ack));

  // Reference model state: bit 16 of a read entry marks a known value.
  logic [15:0] m_mar;
  logic        m_full, m_dv;
  logic [7:0]  m_kbdr, m_dc;
  logic [15:0] m_mem [int];
  logic [16:0] m_rd [0:2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [16:0] mdec();
    if (m_mar < 16'hFE00) begin
      if (m_mem.exists(int'(m_mar[11:0]))) return {1'b1, m_mem[int'(m_mar[11:0])]};
      return 17'h00000;
    end
    case (m_mar)
      16'hFE00: return {1'b1, m_full, 15'b0};
      16'hFE02: return {1'b1, 8'h00, m_kbdr};
      16'hFE04: return {1'b1, ~m_dv, 15'b0};
      16'hFE06: return {1'b1, 8'h00, m_dc};
      default:  return 17'h10000;
    endcase
  endfunction

  task automatic cyc(input logic r, input logic ld, input logic [15:0] a, input logic we,
                     input logic [15:0] d, input logic kv, input logic [7:0] kc, input logic ak);
    logic [16:0] rv;
    rst = r; ldMAR = ld; addr = a; memWE = we; data_in = d;
    kbd_valid = kv; kbd_char = kc; ddr_ack = ak;
    if (r) begin
      m_mar = 16'h0000; m_full = 1'b0; m_kbdr = 8'h00; m_dv = 1'b0; m_dc = 8'h00;
      for (int i = 0; i < 3; i++) m_rd[i] = 17'h10000;
    end else begin
      rv = mdec();
      if (we && m_mar < 16'hFE00) m_mem[int'(m_mar[11:0])] = d;
      if (ak && m_dv) m_dv = 1'b0;
      else if (we && m_mar == 16'hFE06 && !m_dv) begin m_dv = 1'b1; m_dc = d[7:0]; end
      if (kv && !m_full) begin m_full = 1'b1; m_kbdr = kc; end
      else if (ld && a == 16'hFE02) m_full = 1'b0;
      if (ld) m_mar = a;
      m_rd[2] = m_rd[1]; m_rd[1] = m_rd[0]; m_rd[0] = rv;
    end
    @(posedge clk);
    #1;
    for (int l = 1; l <= 3; l++) begin
      if (m_rd[l-1][16]) chk($sformatf("data_out_lat%0d", l), dout[l], m_rd[l-1][15:0]);
      chk($sformatf("kbd_ready_lat%0d", l), {15'b0, kr[l]}, {15'b0, ~m_full});
      chk($sformatf("ddr_valid_lat%0d", l), {15'b0, dv[l]}, {15'b0, m_dv});
      chk($sformatf("ddr_char_lat%0d", l), {8'h00, dc[l]}, {8'h00, m_dc});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic ld_mar(input logic [15:0] a);
    cyc(1'b0, 1'b1, a, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [15:0] d);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, d, 1'b0, 8'h00, 1'b0);
  endtask

  logic [15:0] ra;

  initial begin
    cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
    chk("reset_dout", dout[1], 16'h0000);
    chk("reset_kbd_ready", {15'b0, kr[1]}, 16'h0001);
    chk("reset_ddr_valid", {15'b0, dv[1]}, 16'h0000);
    ld_mar(16'hFE04); idle(3);
    chk("dsr_idle_lat3", dout[3], 16'h8000);

    ld_mar(16'h3000); wr(16'hBEEF); ld_mar(16'h3000);
    idle(1); chk("ram_lat1", dout[1], 16'hBEEF);
    idle(1); chk("ram_lat2", dout[2], 16'hBEEF);
    idle(1); chk("ram_lat3", dout[3], 16'hBEEF);

    ld_mar(16'h0005); wr(16'h1234); ld_mar(16'h1005); idle(3);
    chk("alias", dout[3], 16'h1234);
    ld_mar(16'hFE00); wr(16'hABCD); idle(3);
    chk("kbsr_write_ignored", dout[3], 16'h0000);

    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'h41, 1'b0);
    chk("kbd_full", {15'b0, kr[1]}, 16'h0000);
    ld_mar(16'hFE00); idle(3); chk("kbsr_full", dout[3], 16'h8000);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'h42, 1'b0);
    cyc(1'b0, 1'b1, 16'hFE02, 1'b0, 16'h0000, 1'b1, 8'h42, 1'b0);
    chk("kbd_clear", {15'b0, kr[1]}, 16'h0001);
    idle(3); chk("kbdr", dout[3], 16'h0041);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'h42, 1'b0);
    chk("kbd_second", {15'b0, kr[1]}, 16'h0000);

    ld_mar(16'hFE06); wr(16'h0148);
    chk("ddr_valid_set", {15'b0, dv[1]}, 16'h0001);
    chk("ddr_char_set", {8'h00, dc[1]}, 16'h0048);
    ld_mar(16'hFE04); idle(3); chk("dsr_busy", dout[3], 16'h0000);
    ld_mar(16'hFE06); wr(16'h0049);
    chk("ddr_drop", {8'h00, dc[1]}, 16'h0048);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
    chk("ddr_ack", {15'b0, dv[1]}, 16'h0000);
    ld_mar(16'hFE04); idle(3); chk("dsr_free", dout[3], 16'h8000);

    ld_mar(16'h3000);
    cyc(1'b0, 1'b1, 16'h4000, 1'b1, 16'h00AA, 1'b0, 8'h00, 1'b0);
    ld_mar(16'h3000); idle(3); chk("coincide_write", dout[3], 16'h00AA);
    ld_mar(16'hFE06); wr(16'h0055);
    cyc(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
    chk("rst_ddr_valid", {15'b0, dv[1]}, 16'h0000);
    chk("rst_dout", dout[1], 16'h0000);

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0: ra = 16'($urandom_range(0, 15));
        1: ra = 16'h1000 + 16'($urandom_range(0, 15));
        2: ra = 16'hFE00 + 16'(2 * $urandom_range(0, 3));
        3: ra = 16'($urandom_range(16'hFE08, 16'hFFFF));
        4: ra = 16'hFE02;
        default: ra = 16'($urandom_range(0, 16'hFDFF));
      endcase
      cyc(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), ra,
          ($urandom_range(0, 2) == 0), 16'($urandom), 1'($urandom_range(0, 1)),
          8'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
